// File: rtl/wide_add_seq.sv
// Multi-word adder: one 32-bit add-with-carry stage reused over NW words, LSW first.
// Latency: out_valid rises NW cycles after the accepting edge.
// Backpressure: results hold while out_ready is low; in_ready stays low until the drain.
module wide_add_seq #(
    parameter int NW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NW-1:0]  a,
    input  logic [32*NW-1:0]  b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NW-1:0]  sum,
    output logic              cout,
    output logic              ovf,
    output logic              busy
);

    localparam int W  = 32 * NW;
    localparam int IW = $clog2(NW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;

    logic [31:0]     word_a;
    logic [31:0]     word_b;
    logic [31:0]     word_sum;
    logic            word_cout;
    logic            accept;
    logic            last;

    // The single shared word adder; operands come from the registered copies only.
    always_comb begin
        word_a = a_r[{idx, 5'd0} +: 32];
        word_b = b_r[{idx, 5'd0} +: 32];
        {word_cout, word_sum} = {1'b0, word_a} + {1'b0, word_b} + {32'd0, carry};
    end

    assign last = (idx == IW'(NW - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == ADD) begin
            sum[{idx, 5'd0} +: 32] <= word_sum;
            carry                  <= word_cout;
            if (last) begin
                // Top word: its sum MSB is the result sign for the overflow test.
                idx  <= '0;
                cout <= word_cout;
                ovf  <= (a_r[W-1] == b_r[W-1]) && (word_sum[31] != a_r[W-1]);
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq (NW=4): vector table plus stall, reset and overlap sequences.
module tb_wide_add_seq;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    wide_add_seq #(.NW(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accepting edge until out_valid; gives up at 20.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        logic [W-1:0] held;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        in_valid = 1'b1;
        chk({nm, "_in_ready"}, W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        a        = ~v.a;
        b        = v.a ^ v.b;
        cin      = ~v.cin;
        chk({nm, "_busy"}, W'(busy), W'(1));
        wait_out(lat);
        chk({nm, "_latency"}, W'(lat), W'(NW));
        chk({nm, "_sum"}, sum, v.sum);
        chk({nm, "_cout"}, W'(cout), W'(v.cout));
        chk({nm, "_ovf"}, W'(ovf), W'(v.ovf));
        held      = sum;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_drain_valid"}, W'(out_valid), W'(0));
        chk({nm, "_drain_ready"}, W'(in_ready), W'(1));
        chk({nm, "_drain_sum_kept"}, sum, held);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held;

        vecs[0] = '{a: W'(5), b: W'(1), cin: 1'b0, sum: W'(6), cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: {W{1'b1}}, b: '0, cin: 1'b1, sum: '0, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: {1'b0, {(W-1){1'b1}}}, b: W'(1), cin: 1'b0,
                    sum: {1'b1, {(W-1){1'b0}}}, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: W'(64'h0000_0000_FFFF_FFFF), b: W'(1), cin: 1'b0,
                    sum: W'(64'h0000_0001_0000_0000), cout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: {1'b1, {(W-1){1'b0}}}, b: {1'b1, {(W-1){1'b0}}}, cin: 1'b0,
                    sum: '0, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: {W{1'b1}}, b: {W{1'b1}}, cin: 1'b1, sum: {W{1'b1}}, cout: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
                    b: 128'h11111111_11111111_11111111_11111111, cin: 1'b0,
                    sum: 128'h23456789_ABCDF001_20FEDCBA_98765432, cout: 1'b0, ovf: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #12;
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_sum", sum, '0);
        chk("reset_cout", W'(cout), W'(0));
        chk("reset_ovf", W'(ovf), W'(0));
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_in_ready", W'(in_ready), W'(1));
        tick();
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Stall in DONE for 10 cycles, then a single-cycle out_ready pulse.
        a = W'(40); b = W'(2); cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        chk("stall_latency", W'(lat), W'(NW));
        chk("stall_sum", sum, W'(43));
        held = sum;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_sum_stable", sum, held);
            chk("stall_in_ready", W'(in_ready), W'(0));
            chk("stall_out_valid", W'(out_valid), W'(1));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_drain_in_ready", W'(in_ready), W'(1));
        chk("stall_drain_out_valid", W'(out_valid), W'(0));
        chk("stall_drain_sum", sum, W'(43));

        // Reset in the second ADD cycle.
        a = 128'hAAAA_0000_0000_0000_0000_0000_0000_1111;
        b = 128'h0000_0000_0000_0000_0000_0000_0000_2222;
        cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("midadd_busy_before", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        chk("midadd_rst_out_valid", W'(out_valid), W'(0));
        chk("midadd_rst_sum", sum, '0);
        chk("midadd_rst_busy", W'(busy), W'(0));
        chk("midadd_rst_in_ready", W'(in_ready), W'(1));
        a = W'(15); b = W'(15); cin = 1'b0; in_valid = 1'b1;
        tick();
        chk("midadd_no_accept_in_rst", W'(busy), W'(0));
        rst = 1'b0;
        in_valid = 1'b0;
        run_vec('{a: W'(15), b: W'(15), cin: 1'b0, sum: W'(30), cout: 1'b0, ovf: 1'b0}, "post_rst");

        // Operands change and in_valid stays high during ADD/DONE.
        a = W'(100); b = W'(23); cin = 1'b0; in_valid = 1'b1;
        tick();
        a = W'(1000); b = W'(7); cin = 1'b1;
        chk("ovl_in_ready_add", W'(in_ready), W'(0));
        wait_out(lat);
        chk("ovl_latency", W'(lat), W'(NW));
        chk("ovl_first_sum", sum, W'(123));
        tick();
        chk("ovl_in_ready_done", W'(in_ready), W'(0));
        chk("ovl_first_sum_held", sum, W'(123));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ovl_no_same_cycle_accept", W'(busy), W'(0));
        chk("ovl_drain_in_ready", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        chk("ovl_second_accepted", W'(busy), W'(1));
        wait_out(lat);
        chk("ovl_second_latency", W'(lat), W'(NW));
        chk("ovl_second_sum", sum, W'(1008));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ovl_second_drain", W'(out_valid), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 The block SHALL have parameter NW, default 4, giving the number of 32-bit words per operand (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operand set on a, b and cin is valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept an operand set.
REQ-006 The block SHALL have port a, input, 32*NW, the first operand.
REQ-007 The block SHALL have port b, input, 32*NW, the second operand.
REQ-008 The block SHALL have port cin, input, 1, the carry into word 0.
REQ-009 The block SHALL have port out_valid, output, 1, meaning sum, cout and ovf are valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, 32*NW, the result a+b+cin modulo 2^(32*NW).
REQ-012 The block SHALL have port cout, output, 1, the carry out of the top bit.
REQ-013 The block SHALL have port ovf, output, 1, the two's-complement signed overflow of the full-width add.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 The block SHALL use exactly one combinational 32-bit add-with-carry datapath, time-multiplexed over the NW words.
REQ-016 The block SHALL implement a three-state FSM: IDLE, ADD and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in ADD and DONE, in_ready SHALL be 0.
REQ-018 On an edge where in_valid and in_ready are both 1, the block SHALL register a, b and cin, clear the word index to 0, load the carry register with cin, and enter ADD.
REQ-019 In ADD, each cycle SHALL add word[idx] of a, word[idx] of b and the carry register; it SHALL write the 32-bit result into sum word idx, store the carry-out in the carry register, and increment idx.
REQ-020 ADD SHALL leave to DONE on the edge that processes idx = NW-1, so out_valid rises exactly NW cycles after the accepting edge (4 for the default).
REQ-021 In DONE, out_valid SHALL be 1; cout SHALL equal the final carry, and ovf SHALL equal (a_msb == b_msb) && (sum_msb != a_msb) computed from the registered operands.
REQ-022 sum, cout and ovf SHALL hold stable while out_valid=1 and out_ready=0, for any number of stall cycles.
REQ-023 On an edge in DONE with out_ready=1, the block SHALL return to IDLE; out_valid SHALL fall the next cycle, and sum, cout and ovf SHALL retain their values.
REQ-024 There SHALL be no same-cycle result drain and new accept; a new operand set is accepted no earlier than the cycle after the return to IDLE.
REQ-025 Changes on a, b and cin while busy=1 SHALL have no effect on the result in progress.
REQ-026 in_valid arriving during ADD or DONE SHALL be ignored, and no operand SHALL be lost; the producer holds in_valid until it sees in_ready.
REQ-027 The carry SHALL propagate across word boundaries, so an all-ones operand plus 1 wraps sum to 0 with cout=1.

Reset
REQ-028 When rst=1, asynchronously and regardless of state (including mid-ADD), the block SHALL set FSM=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0 and in_ready=1.
REQ-029 While rst=1, the block SHALL accept no operands.
REQ-030 After rst is released, the first accept SHALL be possible on the first rising edge.

Verification
REQ-031 With NW=4, the bench SHALL apply a=5, b=1, cin=0 -> out_valid 4 cycles after accept, sum=6, cout=0, ovf=0.
REQ-032 The bench SHALL apply a=2^128-1, b=0, cin=1 -> sum=0, cout=1, ovf=0, with the carry rippling through all 4 words.
REQ-033 The bench SHALL apply a=0x7FFF...F (128-bit), b=1, cin=0 -> sum=0x8000...0, cout=0, ovf=1.
REQ-034 The bench SHALL hold out_ready=0 for 10 cycles in DONE -> sum stable, in_ready=0; it SHALL then pulse out_ready -> IDLE with in_ready=1 next cycle.
REQ-035 The bench SHALL assert rst in the 2nd ADD cycle -> immediate out_valid=0, sum=0, busy=0; a post-reset add of 15+15 -> sum=30.
REQ-036 The bench SHALL change a and b and hold in_valid=1 during ADD -> the original result is unaffected, and the second set is accepted only after the drain.
